isa_cycle_gen: RTL and testbench

ISA bus initiator that turns single-byte CPU-side requests into ISA I/O and memory cycles toward the video adapter and other bus responders. It drives address, AEN, data and exactly one of the four strobes with parameterised setup, strobe and hold timing, and stretches the strobe while the responder holds `bus_rdy` low. On read cycles it captures the responder's data, and returns one response per request. It sits between the CPU/bus-arbiter logic and the adapter's bus-facing ports, in the same clock domain.

---
 rtl/isa_cycle_gen_if.sv | 36 +++
 rtl/isa_cycle_gen.sv | 164 ++++++++++++++++
 tb/tb_isa_cycle_gen.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_cycle_gen_if.sv
// Signal bundle between the CPU-side request logic, the ISA cycle initiator and the bus responders.
// master: the initiator; slave: the environment it talks to.
interface isa_cycle_gen_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_io;
  logic        req_write;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [19:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_d_oe;
  logic        bus_ior_l;
  logic        bus_iow_l;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_in;
  logic        bus_dir;
  logic        bus_rdy;

  modport master (
    input  req_valid, req_io, req_write, req_addr, req_wdata, bus_in, bus_dir, bus_rdy,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout, bus_a, bus_d, bus_d_oe,
           bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen
  );

  modport slave (
    output req_valid, req_io, req_write, req_addr, req_wdata, bus_in, bus_dir, bus_rdy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout, bus_a, bus_d, bus_d_oe,
           bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen
  );
endinterface

// File: rtl/isa_cycle_gen.sv
// ISA bus initiator: turns single-byte requests into I/O or memory cycles with setup, strobe,
// wait-state stretching with timeout, and hold phases; returns one response per request.
module isa_cycle_gen #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 6,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned RDY_TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            reset_l,
  isa_cycle_gen_if.master isa
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StWait, StHold} state_e;

  localparam logic [15:0] SetupLast  = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] StrobeLast = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] HoldLast   = 16'(HOLD_CYCLES - 1);
  localparam logic [7:0]  TmoLast    = 8'(RDY_TIMEOUT - 1);
  localparam bit          WaitEn     = (RDY_TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [15:0] phase_q, phase_d;
  logic [7:0]  wait_q, wait_d;
  logic        io_q, io_d, write_q, write_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        handshake, capture, tmo, strobe_on;
  logic        ready_d, rsp_valid_d, timeout_d, aen_d, d_oe_d;
  logic        ior_d, iow_d, memr_d, memw_d;
  logic [7:0]  rdata_d;

  assign handshake = isa.req_valid && (state_q == StIdle);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q         <= StIdle;
      phase_q         <= '0;
      wait_q          <= '0;
      io_q            <= 1'b0;
      write_q         <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      isa.req_ready   <= 1'b1;
      isa.rsp_valid   <= 1'b0;
      isa.rsp_rdata   <= '0;
      isa.rsp_timeout <= 1'b0;
      isa.bus_a       <= '0;
      isa.bus_d       <= '0;
      isa.bus_d_oe    <= 1'b0;
      isa.bus_aen     <= 1'b1;
      isa.bus_ior_l   <= 1'b1;
      isa.bus_iow_l   <= 1'b1;
      isa.bus_memr_l  <= 1'b1;
      isa.bus_memw_l  <= 1'b1;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      wait_q          <= wait_d;
      io_q            <= io_d;
      write_q         <= write_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      isa.req_ready   <= ready_d;
      isa.rsp_valid   <= rsp_valid_d;
      isa.rsp_rdata   <= rdata_d;
      isa.rsp_timeout <= timeout_d;
      isa.bus_a       <= addr_d;
      isa.bus_d       <= wdata_d;
      isa.bus_d_oe    <= d_oe_d;
      isa.bus_aen     <= aen_d;
      isa.bus_ior_l   <= ior_d;
      isa.bus_iow_l   <= iow_d;
      isa.bus_memr_l  <= memr_d;
      isa.bus_memw_l  <= memw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wait_d  = wait_q;
    io_d    = io_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    capture = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d = StSetup;
          phase_d = '0;
          io_d    = isa.req_io;
          write_d = isa.req_write;
          addr_d  = isa.req_addr;
          wdata_d = isa.req_wdata;
        end
      end
      StSetup: begin
        if (phase_q == SetupLast) begin
          state_d = StStrobe;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      StStrobe: begin
        if (phase_q == StrobeLast) begin
          phase_d = '0;
          if (WaitEn && !isa.bus_rdy) begin
            state_d = StWait;
            wait_d  = '0;
          end else begin
            state_d = StHold;
            capture = 1'b1;
          end
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      StWait: begin
        // A ready responder wins over a timeout expiring on the same edge.
        if (isa.bus_rdy) begin
          state_d = StHold;
          capture = 1'b1;
        end else if (wait_q == TmoLast) begin
          state_d = StHold;
          capture = 1'b1;
          tmo     = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StHold: begin
        if (phase_q == HoldLast) begin
          state_d = StIdle;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so the bus lines up with the state they describe.
  always_comb begin
    strobe_on   = (state_d == StStrobe) || (state_d == StWait);
    ready_d     = (state_d == StIdle);
    rsp_valid_d = (state_q == StHold) && (state_d == StIdle);
    aen_d       = (state_d == StIdle);
    d_oe_d      = (state_d != StIdle) && write_d;
    ior_d       = !(strobe_on && io_d && !write_d);
    iow_d       = !(strobe_on && io_d && write_d);
    memr_d      = !(strobe_on && !io_d && !write_d);
    memw_d      = !(strobe_on && !io_d && write_d);
    rdata_d     = isa.rsp_rdata;
    if (capture && !write_q) begin
      rdata_d = (tmo || !isa.bus_dir) ? 8'hFF : isa.bus_in;
    end
    timeout_d = capture ? tmo : isa.rsp_timeout;
  end

endmodule

// File: tb/tb_isa_cycle_gen.sv
// Randomised scoreboard bench for isa_cycle_gen with a reactive bus responder.
module tb_isa_cycle_gen;
  localparam int unsigned SetupCyc  = 2;
  localparam int unsigned StrobeCyc = 6;
  localparam int unsigned HoldCyc   = 1;
  localparam int unsigned TmoCyc    = 8;
  localparam int unsigned Stuck     = 1000;

  typedef struct {
    bit          io;
    bit          wr;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    bit          tmo;
    int unsigned waits;
    int          accept;
  } exp_t;

  typedef struct {
    bit          dir;
    logic [7:0]  din;
    int unsigned w;
  } cfg_t;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  isa_cycle_gen_if ifc ();

  exp_t       exp_q[$];
  cfg_t       cfg_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] model_rdata = 8'h00;
  logic       strobe_low;

  isa_cycle_gen #(
    .SETUP_CYCLES (SetupCyc),
    .STROBE_CYCLES(StrobeCyc),
    .HOLD_CYCLES  (HoldCyc),
    .RDY_TIMEOUT  (TmoCyc)
  ) dut (
    .clk    (clk),
    .reset_l(reset_l),
    .isa    (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign strobe_low = !(ifc.bus_ior_l && ifc.bus_iow_l && ifc.bus_memr_l && ifc.bus_memw_l);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_strobes(input bit io, input bit wr);
    return {!(io && !wr), !(io && wr), !(!io && !wr), !(!io && wr)};
  endfunction

  // Responder: holds bus_rdy low for w cycles beyond the minimum strobe, w=Stuck never ready.
  initial begin
    int unsigned k;
    int unsigned kn;
    k = 0;
    ifc.bus_rdy = 1'b1;
    ifc.bus_dir = 1'b0;
    ifc.bus_in  = 8'h00;
    forever begin
      @(negedge clk);
      kn = (strobe_low && reset_l) ? k + 1 : 0;
      if (k != 0 && kn == 0 && cfg_q.size() != 0) void'(cfg_q.pop_front());
      k = kn;
      if (cfg_q.size() != 0) begin
        ifc.bus_rdy = (kn >= StrobeCyc + cfg_q[0].w);
        ifc.bus_dir = cfg_q[0].dir;
        ifc.bus_in  = cfg_q[0].din;
      end else begin
        ifc.bus_rdy = 1'b1;
        ifc.bus_dir = 1'b0;
        ifc.bus_in  = 8'h00;
      end
    end
  end

  // Monitor: accumulates bus behaviour per cycle and scores it on each response.
  initial begin
    int   aen_cnt, stb_cnt, pre_cnt, post_cnt;
    bit   bad_kind, bad_bus;
    exp_t e;
    int unsigned weff;
    aen_cnt = 0; stb_cnt = 0; pre_cnt = 0; post_cnt = 0; bad_kind = 0; bad_bus = 0;
    forever begin
      @(negedge clk);
      if (!reset_l) begin
        aen_cnt = 0; stb_cnt = 0; pre_cnt = 0; post_cnt = 0; bad_kind = 0; bad_bus = 0;
      end else if (ifc.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          weff = (e.waits > TmoCyc) ? TmoCyc : e.waits;
          chk("latency", 32'(cyc - e.accept), 32'(SetupCyc + StrobeCyc + HoldCyc + 1 + weff));
          chk("strobe_len", 32'(stb_cnt), 32'(StrobeCyc + weff));
          chk("setup_len", 32'(pre_cnt), 32'(SetupCyc));
          chk("hold_len", 32'(post_cnt), 32'(HoldCyc));
          chk("strobe_select_ok", 32'(bad_kind), 32'd0);
          chk("bus_addr_data_ok", 32'(bad_bus), 32'd0);
          chk("rsp_timeout", 32'(ifc.rsp_timeout), 32'(e.tmo));
          chk("rsp_rdata", 32'(ifc.rsp_rdata), 32'(e.rdata));
        end
        aen_cnt = 0; stb_cnt = 0; pre_cnt = 0; post_cnt = 0; bad_kind = 0; bad_bus = 0;
      end else if (!ifc.bus_aen) begin
        if (exp_q.size() == 0) begin
          bad_bus = 1;
        end else begin
          e = exp_q[0];
          aen_cnt++;
          if (strobe_low) begin
            stb_cnt++;
            if ({ifc.bus_ior_l, ifc.bus_iow_l, ifc.bus_memr_l, ifc.bus_memw_l}
                !== exp_strobes(e.io, e.wr)) bad_kind = 1;
          end else if (stb_cnt == 0) begin
            pre_cnt++;
          end else begin
            post_cnt++;
          end
          if (ifc.bus_a !== e.addr || ifc.bus_d_oe !== e.wr || (e.wr && ifc.bus_d !== e.wdata))
            bad_bus = 1;
        end
      end else if (strobe_low || ifc.bus_d_oe) begin
        checks++;
        errors++;
        $display("FAIL idle_bus: got strobe/oe active with aen=1, expected released (t=%0t)",
                 $time);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake with req_valid still high.
  task automatic issue(input bit io, input bit wr, input logic [19:0] a, input logic [7:0] wd,
                       input bit dir, input logic [7:0] din, input int unsigned w, input bit b2b);
    exp_t e;
    cfg_t c;
    int   n;
    ifc.req_valid = 1'b1;
    ifc.req_io    = io;
    ifc.req_write = wr;
    ifc.req_addr  = a;
    ifc.req_wdata = wd;
    n = 0;
    while (!ifc.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 for 200 cycles, expected 1");
      ifc.req_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_accept_in_rsp_cycle", 32'(ifc.rsp_valid), 32'd1);
    e.io = io; e.wr = wr; e.addr = a; e.wdata = wd; e.waits = w; e.accept = cyc;
    e.tmo = (w >= TmoCyc);
    if (wr) e.rdata = model_rdata;
    else if (e.tmo || !dir) e.rdata = 8'hFF;
    else e.rdata = din;
    model_rdata = e.rdata;
    c.dir = dir; c.din = din; c.w = w;
    exp_q.push_back(e);
    cfg_q.push_back(c);
    @(negedge clk);
  endtask

  initial begin
    bit b2b;
    int n;
    ifc.req_valid = 1'b0;
    ifc.req_io    = 1'b0;
    ifc.req_write = 1'b0;
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(ifc.rsp_rdata), 32'd0);
    chk("rst_rsp_timeout", 32'(ifc.rsp_timeout), 32'd0);
    chk("rst_strobes", 32'({ifc.bus_ior_l, ifc.bus_iow_l, ifc.bus_memr_l, ifc.bus_memw_l}), 32'hF);
    chk("rst_aen", 32'(ifc.bus_aen), 32'd1);
    chk("rst_bus_a", 32'(ifc.bus_a), 32'd0);
    chk("rst_bus_d", 32'(ifc.bus_d), 32'd0);
    chk("rst_bus_d_oe", 32'(ifc.bus_d_oe), 32'd0);
    reset_l = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases: I/O write, I/O read, memory read floating, wait states, timeout.
    issue(1'b1, 1'b1, 20'h003D8, 8'h29, 1'b0, 8'h00, 0, 1'b0);
    ifc.req_valid = 1'b0;
    issue(1'b1, 1'b0, 20'h003DA, 8'h00, 1'b1, 8'hF9, 0, 1'b0);
    ifc.req_valid = 1'b0;
    issue(1'b0, 1'b0, 20'hB8000, 8'h00, 1'b0, 8'h12, 0, 1'b0);
    ifc.req_valid = 1'b0;
    issue(1'b0, 1'b0, 20'hA0000, 8'h00, 1'b1, 8'h3C, 4, 1'b0);
    ifc.req_valid = 1'b0;
    issue(1'b1, 1'b0, 20'h003DA, 8'h00, 1'b1, 8'h55, Stuck, 1'b0);
    ifc.req_valid = 1'b0;
    issue(1'b0, 1'b1, 20'hB8001, 8'h07, 1'b0, 8'h00, 0, 1'b0);
    issue(1'b1, 1'b0, 20'h003C5, 8'h00, 1'b1, 8'h81, 0, 1'b1);
    ifc.req_valid = 1'b0;

    b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int unsigned w;
      w = ($urandom_range(0, 3) == 0) ? Stuck
        : (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7));
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 20'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom), w, b2b);
      if ($urandom_range(0, 2) == 0) begin
        b2b = 1'b1;
      end else begin
        b2b = 1'b0;
        ifc.req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    ifc.req_valid = 1'b0;

    // Reset in the middle of a write strobe: bus released at once, response discarded.
    n = 0;
    while (!ifc.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    issue(1'b1, 1'b1, 20'h12345, 8'hA5, 1'b0, 8'h00, 0, 1'b0);
    ifc.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("iow_low_before_reset", 32'(ifc.bus_iow_l), 32'd0);
    #2 reset_l = 1'b0;
    #1;
    chk("midrst_strobes", 32'({ifc.bus_ior_l, ifc.bus_iow_l, ifc.bus_memr_l, ifc.bus_memw_l}),
        32'hF);
    chk("midrst_aen", 32'(ifc.bus_aen), 32'd1);
    chk("midrst_d_oe", 32'(ifc.bus_d_oe), 32'd0);
    chk("midrst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    exp_q.delete();
    cfg_q.delete();
    model_rdata = 8'h00;
    @(negedge clk);
    #2 reset_l = 1'b1;
    @(negedge clk);
    chk("postrst_req_ready", 32'(ifc.req_ready), 32'd1);
    repeat (15) @(negedge clk);

    issue(1'b0, 1'b1, 20'hC0000, 8'h5A, 1'b0, 8'h00, 2, 1'b0);
    ifc.req_valid = 1'b0;
    issue(1'b0, 1'b0, 20'hC0001, 8'h00, 1'b1, 8'hC3, 0, 1'b0);
    ifc.req_valid = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
    end
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
